// File: rtl/inc_seq_checker_pkg.sv
// inc_seq_checker_pkg: shared state encoding for the increment-sequence checker
package inc_seq_checker_pkg;
    localparam int ST_W = 2;
    typedef enum logic [ST_W-1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_e;
endpackage

// File: rtl/inc_seq_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter
    import inc_seq_checker_pkg::*;
#(
    parameter int P_CNT_W = 16
) (
    input  logic               CLK_I,
    input  logic               RST_X,
    input  logic               CLR_I,
    input  logic               INC_I,
    output logic [P_CNT_W-1:0] CNT_O
);
    logic [P_CNT_W-1:0] cnt_q;
    assign CNT_O = cnt_q;
    // count up, hold at all-ones, clear wins over a simultaneous increment
    always_ff @(posedge CLK_I or negedge RST_X) begin
        if (!RST_X) cnt_q <= '0;
        else if (CLR_I) cnt_q <= '0;
        else if (INC_I && !(&cnt_q)) cnt_q <= cnt_q + P_CNT_W'(1);
    end
endmodule

// File: rtl/inc_seq_checker.sv
// inc_seq_checker: hunts, locks onto and monitors a free-running +1 data stream
module inc_seq_checker
    import inc_seq_checker_pkg::*;
#(
    parameter int P_WIDTH    = 8,
    parameter int P_LOCK_CNT = 4,
    parameter int P_LOSS_CNT = 3,
    parameter int P_CNT_W    = 16
) (
    input  logic               CLK_I,
    input  logic               RST_X,
    input  logic [P_WIDTH-1:0] DATA_I,
    input  logic               VALID_I,
    input  logic               CLR_I,
    output logic               LOCKED_O,
    output logic               ERR_O,
    output logic [P_WIDTH-1:0] EXPECT_O,
    output logic [P_CNT_W-1:0] ERR_CNT_O,
    output logic [P_CNT_W-1:0] SAMPLE_CNT_O
);
    localparam int GW = $clog2(P_LOCK_CNT + 1);
    localparam int BW = $clog2(P_LOSS_CNT + 1);
    state_e             state_q, state_d;
    logic [P_WIDTH-1:0] expect_q, expect_d;
    logic [GW-1:0]      good_q, good_d, good_inc;
    logic [BW-1:0]      bad_q, bad_d, bad_inc;
    logic               err_q, err_d;
    assign LOCKED_O = (state_q == ST_LOCK);
    assign ERR_O    = err_q;
    assign EXPECT_O = expect_q;
    assign good_inc = good_q + GW'(1);
    assign bad_inc  = bad_q + BW'(1);
    // next state: SYNC reseeds from the data, LOCK flywheels on its own expectation
    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_d    = 1'b0;
        if (VALID_I) begin
            case (state_q)
                ST_HUNT: begin
                    expect_d = DATA_I + P_WIDTH'(1);
                    good_d   = '0;
                    state_d  = ST_SYNC;
                end
                ST_SYNC: begin
                    expect_d = DATA_I + P_WIDTH'(1);
                    good_d   = (DATA_I == expect_q) ? good_inc : '0;
                    if (DATA_I == expect_q && good_inc == GW'(P_LOCK_CNT)) begin
                        state_d = ST_LOCK;
                        bad_d   = '0;
                    end
                end
                ST_LOCK: begin
                    expect_d = expect_q + P_WIDTH'(1);
                    err_d    = (DATA_I != expect_q);
                    bad_d    = err_d ? bad_inc : '0;
                    if (err_d && bad_inc == BW'(P_LOSS_CNT)) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end
    // state, expectation, run-length counters and error pulse registers
    always_ff @(posedge CLK_I or negedge RST_X) begin
        if (!RST_X) begin
            state_q  <= ST_HUNT;
            expect_q <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
        end
    end
    sat_counter #(.P_CNT_W(P_CNT_W)) u_err_cnt (
        .CLK_I (CLK_I),
        .RST_X (RST_X),
        .CLR_I (CLR_I),
        .INC_I (err_d),
        .CNT_O (ERR_CNT_O)
    );
    sat_counter #(.P_CNT_W(P_CNT_W)) u_sample_cnt (
        .CLK_I (CLK_I),
        .RST_X (RST_X),
        .CLR_I (CLR_I),
        .INC_I (VALID_I),
        .CNT_O (SAMPLE_CNT_O)
    );
endmodule

// File: tb/tb_inc_seq_checker.sv
// tb_inc_seq_checker: directed scoreboard bench for the increment-sequence checker
module tb_inc_seq_checker;
    typedef struct packed {
        logic        l;
        logic        e;
        logic [7:0]  x;
        logic [15:0] c;
        logic [15:0] s;
    } resp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  data = '0;
    logic        locked, err;
    logic [7:0]  expect_w;
    logic [15:0] err_cnt, sample_cnt;
    resp_t       exp_q[$];
    resp_t       mon_exp, mon_got;
    int          n_chk = 0;
    int          n_pass = 0;
    inc_seq_checker dut (
        .CLK_I        (clk),
        .RST_X        (rst_n),
        .DATA_I       (data),
        .VALID_I      (valid),
        .CLR_I        (clr),
        .LOCKED_O     (locked),
        .ERR_O        (err),
        .EXPECT_O     (expect_w),
        .ERR_CNT_O    (err_cnt),
        .SAMPLE_CNT_O (sample_cnt)
    );
    always #5 clk = ~clk;
    task automatic step(input logic v, input logic [7:0] d, input logic c,
                        input logic l, input logic e, input logic [7:0] x,
                        input int ce, input int cs);
        @(negedge clk);
        valid = v;
        data  = d;
        clr   = c;
        exp_q.push_back(resp_t'{l, e, x, 16'(ce), 16'(cs)});
        @(posedge clk);
        #1;
        valid = 1'b0;
        clr   = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d responses still pending, want 0", exp_q.size());
        end
    endtask
    task automatic check_zero(input string name);
        n_chk++;
        if ({locked, err, expect_w, err_cnt, sample_cnt} == '0) n_pass++;
        else $display("FAIL %s: got l=%b e=%b x=%h c=%0d s=%0d, want all zero",
                      name, locked, err, expect_w, err_cnt, sample_cnt);
    endtask
    // monitor: the response to each driven cycle is compared just after the following edge
    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = resp_t'{locked, err, expect_w, err_cnt, sample_cnt};
            n_chk++;
            if (mon_got == mon_exp) n_pass++;
            else $display("FAIL resp@%0t: got l=%b e=%b x=%h c=%0d s=%0d, want l=%b e=%b x=%h c=%0d s=%0d",
                          $time, mon_got.l, mon_got.e, mon_got.x, mon_got.c, mon_got.s,
                          mon_exp.l, mon_exp.e, mon_exp.x, mon_exp.c, mon_exp.s);
        end
    end
    initial begin
        #3 check_zero("reset");
        #9 rst_n = 1'b1;
        step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        // 1: acquire lock on 0x10..0x14
        step(1, 8'h10, 0, 0, 0, 8'h11, 0, 1);
        step(1, 8'h11, 0, 0, 0, 8'h12, 0, 2);
        step(1, 8'h12, 0, 0, 0, 8'h13, 0, 3);
        step(1, 8'h13, 0, 0, 0, 8'h14, 0, 4);
        step(1, 8'h14, 0, 1, 0, 8'h15, 0, 5);
        for (int d = 'h15; d <= 'h20; d++) step(1, 8'(d), 0, 1, 0, 8'(d + 1), 0, d - 'h15 + 6);
        // 2: single bad word while locked
        step(1, 8'h21, 0, 1, 0, 8'h22, 0, 18);
        step(1, 8'h99, 0, 1, 1, 8'h23, 1, 19);
        step(1, 8'h23, 0, 1, 0, 8'h24, 1, 20);
        // 3: run up to and across the wrap
        for (int d = 'h24; d <= 'hFD; d++) step(1, 8'(d), 0, 1, 0, 8'(d + 1), 1, d - 'h23 + 20);
        step(1, 8'hFE, 0, 1, 0, 8'hFF, 1, 239);
        step(1, 8'hFF, 0, 1, 0, 8'h00, 1, 240);
        step(1, 8'h00, 0, 1, 0, 8'h01, 1, 241);
        step(1, 8'h01, 0, 1, 0, 8'h02, 1, 242);
        // 4: three bad words lose lock, then relock
        step(1, 8'h55, 0, 1, 1, 8'h03, 2, 243);
        step(1, 8'h55, 0, 1, 1, 8'h04, 3, 244);
        step(1, 8'h55, 0, 0, 1, 8'h05, 4, 245);
        step(1, 8'h30, 0, 0, 0, 8'h31, 4, 246);
        step(1, 8'h31, 0, 0, 0, 8'h32, 4, 247);
        step(1, 8'h32, 0, 0, 0, 8'h33, 4, 248);
        step(1, 8'h33, 0, 0, 0, 8'h34, 4, 249);
        step(1, 8'h34, 0, 1, 0, 8'h35, 4, 250);
        // 5: clear coinciding with an erroring word
        step(1, 8'h77, 1, 1, 1, 8'h36, 0, 0);
        step(1, 8'h36, 0, 1, 0, 8'h37, 0, 1);
        // 6: gaps with garbage data while locked
        step(1, 8'h37, 0, 1, 0, 8'h38, 0, 2);
        step(0, 8'hC3, 0, 1, 0, 8'h38, 0, 2);
        step(1, 8'h38, 0, 1, 0, 8'h39, 0, 3);
        step(0, 8'hAA, 0, 1, 0, 8'h39, 0, 3);
        step(1, 8'h39, 0, 1, 0, 8'h3A, 0, 4);
        drain();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        // SYNC mismatch reseeds and restarts the good run
        step(1, 8'h40, 0, 0, 0, 8'h41, 0, 1);
        step(1, 8'h41, 0, 0, 0, 8'h42, 0, 2);
        step(1, 8'h50, 0, 0, 0, 8'h51, 0, 3);
        step(1, 8'h51, 0, 0, 0, 8'h52, 0, 4);
        step(1, 8'h52, 0, 0, 0, 8'h53, 0, 5);
        step(1, 8'h53, 0, 0, 0, 8'h54, 0, 6);
        step(1, 8'h54, 0, 1, 0, 8'h55, 0, 7);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
